// File: rtl/mem_port_arbiter.sv
// Two-requester round-robin arbiter for one shared 16-bit RAM port, with a burst cap.
// Optional per-requester transfer counters are enabled by defining ARB_GRANT_CNT_EN.
module mem_port_arbiter #(
  parameter int unsigned MAX_BURST = 4,
  parameter int unsigned AW        = 15
) (
  input  logic          clk,
  input  logic          reset,

  input  logic          req_a,
  input  logic          load_a,
  input  logic [AW-1:0] addr_a,
  input  logic [15:0]   in_a,
  output logic          gnt_a,

  input  logic          req_b,
  input  logic          load_b,
  input  logic [AW-1:0] addr_b,
  input  logic [15:0]   in_b,
  output logic          gnt_b,

  output logic [AW-1:0] mem_addr,
  output logic [15:0]   mem_in,
  output logic          mem_load,
  output logic          sel,
  output logic          busy
`ifdef ARB_GRANT_CNT_EN
  ,
  output logic [15:0]   cnt_a,
  output logic [15:0]   cnt_b
`endif
);

  typedef enum logic [1:0] {
    StIdle,
    StOwnA,
    StOwnB
  } owner_e;

  localparam logic [3:0] MaxBurst = 4'(MAX_BURST);
  localparam logic       SelA     = 1'b0;
  localparam logic       SelB     = 1'b1;

  owner_e     owner_q, owner_d;
  logic       last_q, last_d;
  logic [3:0] burst_q, burst_d;
  logic [3:0] burst_inc;
  logic       pick_a, pick_b;

  assign burst_inc = (burst_q == 4'hF) ? 4'hF : burst_q + 4'd1;

  // Grant decision: the current owner keeps the port until the cap is hit under contention.
  always_comb begin
    pick_a = 1'b0;
    pick_b = 1'b0;
    if (!reset) begin
      case (owner_q)
        StIdle: begin
          if (req_a && req_b) begin
            if (last_q == SelB) pick_a = 1'b1;
            else                pick_b = 1'b1;
          end else if (req_a) begin
            pick_a = 1'b1;
          end else if (req_b) begin
            pick_b = 1'b1;
          end
        end
        StOwnA: begin
          if (req_a && (!req_b || (burst_q < MaxBurst))) pick_a = 1'b1;
          else if (req_b)                                 pick_b = 1'b1;
        end
        StOwnB: begin
          if (req_b && (!req_a || (burst_q < MaxBurst))) pick_b = 1'b1;
          else if (req_a)                                 pick_a = 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign gnt_a = pick_a;
  assign gnt_b = pick_b;

  always_comb begin
    owner_d = StIdle;
    burst_d = 4'd0;
    last_d  = last_q;
    if (pick_a) begin
      owner_d = StOwnA;
      burst_d = (owner_q == StOwnA) ? burst_inc : 4'd1;
      last_d  = SelA;
    end else if (pick_b) begin
      owner_d = StOwnB;
      burst_d = (owner_q == StOwnB) ? burst_inc : 4'd1;
      last_d  = SelB;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      owner_q  <= StIdle;
      last_q   <= SelB;
      burst_q  <= 4'd0;
      mem_addr <= '0;
      mem_in   <= 16'h0000;
      mem_load <= 1'b0;
      sel      <= SelA;
      busy     <= 1'b0;
    end else begin
      owner_q  <= owner_d;
      last_q   <= last_d;
      burst_q  <= burst_d;
      busy     <= pick_a | pick_b;
      mem_load <= (pick_a & load_a) | (pick_b & load_b);
      // Address, data and sel hold their last values on idle cycles.
      if (pick_a) begin
        mem_addr <= addr_a;
        mem_in   <= in_a;
        sel      <= SelA;
      end else if (pick_b) begin
        mem_addr <= addr_b;
        mem_in   <= in_b;
        sel      <= SelB;
      end
    end
  end

`ifdef ARB_GRANT_CNT_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_a <= 16'h0000;
      cnt_b <= 16'h0000;
    end else begin
      if (pick_a) cnt_a <= cnt_a + 16'd1;
      if (pick_b) cnt_b <= cnt_b + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: the driver pushes expected port cycles, a monitor
// pops and compares them on the falling edge. Counter checks apply when ARB_GRANT_CNT_EN is set.
module tb_mem_port_arbiter;

  logic        clk;
  logic        reset;
  logic        req_a, load_a, gnt_a;
  logic [14:0] addr_a;
  logic [15:0] in_a;
  logic        req_b, load_b, gnt_b;
  logic [14:0] addr_b;
  logic [15:0] in_b;
  logic [14:0] mem_addr;
  logic [15:0] mem_in;
  logic        mem_load, sel, busy;
`ifdef ARB_GRANT_CNT_EN
  logic [15:0] cnt_a, cnt_b;
`endif

  mem_port_arbiter #(
    .MAX_BURST(4),
    .AW(15)
  ) dut (
    .clk(clk),
    .reset(reset),
    .req_a(req_a),
    .load_a(load_a),
    .addr_a(addr_a),
    .in_a(in_a),
    .gnt_a(gnt_a),
    .req_b(req_b),
    .load_b(load_b),
    .addr_b(addr_b),
    .in_b(in_b),
    .gnt_b(gnt_b),
    .mem_addr(mem_addr),
    .mem_in(mem_in),
    .mem_load(mem_load),
    .sel(sel),
    .busy(busy)
`ifdef ARB_GRANT_CNT_EN
    ,
    .cnt_a(cnt_a),
    .cnt_b(cnt_b)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [14:0] addr;
    logic [15:0] data;
    logic        load;
    logic        sel;
    int          due;
  } txn_t;

  txn_t q[$];
  int   n_checks = 0;
  int   n_pass   = 0;
  int   cyc      = 0;

  // Requester-side transaction state; advanced only on an expected grant.
  logic [14:0] a_addr, b_addr;
  logic [15:0] a_data, b_data;
  logic        a_load, b_load;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
  endtask

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // exp: 0 = no grant, 1 = grant A, 2 = grant B
  task automatic step(input logic rst, input logic ra, input logic rb, input int exp);
    txn_t t;
    reset  = rst;
    req_a  = ra;
    req_b  = rb;
    addr_a = a_addr;
    in_a   = a_data;
    load_a = a_load;
    addr_b = b_addr;
    in_b   = b_data;
    load_b = b_load;
    @(negedge clk);
    chk("gnt_a", {31'd0, gnt_a}, {31'd0, exp == 1});
    chk("gnt_b", {31'd0, gnt_b}, {31'd0, exp == 2});
    if (exp == 1) begin
      t = '{addr: a_addr, data: a_data, load: a_load, sel: 1'b0, due: cyc + 1};
      q.push_back(t);
      a_addr = a_addr + 15'd1;
      a_data = a_data + 16'h1111;
    end else if (exp == 2) begin
      t = '{addr: b_addr, data: b_data, load: b_load, sel: 1'b1, due: cyc + 1};
      q.push_back(t);
      b_addr = b_addr + 15'd1;
      b_data = b_data + 16'h0101;
    end
    @(posedge clk);
    #1;
  endtask

  // Monitor: compares the registered port against the scoreboard every cycle.
  initial begin
    txn_t        t;
    logic [14:0] h_addr;
    logic [15:0] h_in;
    logic        h_sel;
    logic        rst_pend;
    logic [15:0] ec_a, ec_b;
    rst_pend = 1'b1;
    h_addr   = '0;
    h_in     = '0;
    h_sel    = 1'b0;
    ec_a     = '0;
    ec_b     = '0;
    @(posedge clk);
    forever begin
      @(negedge clk);
      if (rst_pend) begin
        h_addr = '0;
        h_in   = '0;
        h_sel  = 1'b0;
        ec_a   = '0;
        ec_b   = '0;
      end
      if (q.size() > 0 && q[0].due == cyc) begin
        t = q.pop_front();
        chk("busy", {31'd0, busy}, 32'd1);
        chk("mem_addr", {17'd0, mem_addr}, {17'd0, t.addr});
        chk("mem_in", {16'd0, mem_in}, {16'd0, t.data});
        chk("mem_load", {31'd0, mem_load}, {31'd0, t.load});
        chk("sel", {31'd0, sel}, {31'd0, t.sel});
        h_addr = t.addr;
        h_in   = t.data;
        h_sel  = t.sel;
        if (t.sel) ec_b = ec_b + 16'd1;
        else       ec_a = ec_a + 16'd1;
      end else begin
        chk("idle_busy", {31'd0, busy}, 32'd0);
        chk("idle_mem_load", {31'd0, mem_load}, 32'd0);
        chk("hold_mem_addr", {17'd0, mem_addr}, {17'd0, h_addr});
        chk("hold_mem_in", {16'd0, mem_in}, {16'd0, h_in});
        chk("hold_sel", {31'd0, sel}, {31'd0, h_sel});
      end
`ifdef ARB_GRANT_CNT_EN
      chk("cnt_a", {16'd0, cnt_a}, {16'd0, ec_a});
      chk("cnt_b", {16'd0, cnt_b}, {16'd0, ec_b});
`endif
      rst_pend = reset;
    end
  end

  initial begin
    int contend[10];
    int t3_ra[12];
    int t3_rb[12];
    int t3_ex[12];
    contend = '{1, 1, 1, 1, 2, 2, 2, 2, 1, 1};
    t3_ra   = '{1, 1, 1, 1, 1, 1, 1, 1, 1, 1, 1, 0};
    t3_rb   = '{0, 0, 0, 1, 1, 0, 1, 1, 1, 1, 0, 0};
    t3_ex   = '{1, 1, 1, 1, 2, 1, 1, 1, 1, 2, 1, 0};

    reset  = 1'b1;
    req_a  = 1'b1;
    req_b  = 1'b1;
    a_addr = 15'h0100;
    a_data = 16'h0A00;
    a_load = 1'b1;
    b_addr = 15'h0200;
    b_data = 16'h0B00;
    b_load = 1'b1;
    addr_a = a_addr;
    in_a   = a_data;
    load_a = a_load;
    addr_b = b_addr;
    in_b   = b_data;
    load_b = b_load;
    @(posedge clk);
    #1;

    // Reset with both requesting: no grants, then A wins the first tie; cap of 4 alternates.
    step(1'b1, 1'b1, 1'b1, 0);
    step(1'b1, 1'b1, 1'b1, 0);
    for (int i = 0; i < 10; i++) step(1'b0, 1'b1, 1'b1, contend[i]);
    step(1'b0, 1'b0, 1'b0, 0);
    step(1'b0, 1'b0, 1'b0, 0);

    // A alone: six back-to-back writes.
    a_addr = 15'h0010;
    a_data = 16'h1111;
    for (int i = 0; i < 6; i++) step(1'b0, 1'b1, 1'b0, 1);
    step(1'b0, 1'b0, 1'b0, 0);
    step(1'b0, 1'b0, 1'b0, 0);

    // A streaming reads, B interjects single writes; A resumes with a fresh burst.
    a_load = 1'b0;
    a_addr = 15'h0300;
    for (int i = 0; i < 12; i++)
      step(1'b0, t3_ra[i] != 0, t3_rb[i] != 0, t3_ex[i]);

    // Long A-only run saturates the burst count, so B must win at once.
    for (int i = 0; i < 18; i++) step(1'b0, 1'b1, 1'b0, 1);
    step(1'b0, 1'b1, 1'b1, 2);
    step(1'b0, 1'b0, 1'b0, 0);

    // Reset on the third A grant: transfer dropped, and the next tie goes to A.
    a_load = 1'b1;
    step(1'b0, 1'b1, 1'b0, 1);
    step(1'b0, 1'b1, 1'b0, 1);
    step(1'b1, 1'b1, 1'b0, 0);
    step(1'b0, 1'b1, 1'b1, 1);
    step(1'b0, 1'b0, 1'b0, 0);
    step(1'b0, 1'b0, 1'b0, 0);

`ifdef ARB_GRANT_CNT_EN
    step(1'b1, 1'b0, 1'b0, 0);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 1'b0, 1);
    for (int i = 0; i < 5; i++) step(1'b0, 1'b0, 1'b1, 2);
    step(1'b0, 1'b0, 1'b0, 0);
    chk("cnt_a_3", {16'd0, cnt_a}, 32'd3);
    chk("cnt_b_5", {16'd0, cnt_b}, 32'd5);

    step(1'b1, 1'b0, 1'b0, 0);
    for (int i = 0; i < 65535; i++) step(1'b0, 1'b1, 1'b0, 1);
    step(1'b0, 1'b0, 1'b0, 0);
    chk("cnt_a_ffff", {16'd0, cnt_a}, 32'h0000_FFFF);
    step(1'b0, 1'b1, 1'b0, 1);
    step(1'b0, 1'b0, 1'b0, 0);
    chk("cnt_a_wrap", {16'd0, cnt_a}, 32'd0);
`endif

    step(1'b0, 1'b0, 1'b0, 0);
    step(1'b0, 1'b0, 1'b0, 0);
    chk("queue_drained", q.size(), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
